// File: rtl/studio2_pkg.sv
// studio2_pkg: shared types and memory-map constants for the Studio II memory arbiter
package studio2_pkg;
  typedef enum logic [2:0] {RG_ROM, RG_CART, RG_PRAM, RG_VRAM, RG_MCART, RG_MIRROR} region_t;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_t;
  typedef enum logic [1:0] {ST_RUN, ST_LOAD, ST_DRAIN} state_t;
  localparam logic [11:0] ROM_BASE    = 12'h000;
  localparam logic [11:0] CART_BASE   = 12'h400;
  localparam logic [11:0] PRAM_BASE   = 12'h800;
  localparam logic [11:0] VRAM_BASE   = 12'h900;
  localparam logic [11:0] MCART_BASE  = 12'hA00;
  localparam logic [11:0] MIRROR_BASE = 12'hC00;
  localparam logic [11:0] MCART2_BASE = 12'hE00;
  localparam logic [24:0] LD_WINDOW   = 25'h400;
  // Region lookup on the folded 12-bit address, ordered by ascending base
  function automatic region_t region_of(input logic [11:0] a);
    return a < CART_BASE   ? RG_ROM   :
           a < PRAM_BASE   ? RG_CART  :
           a < VRAM_BASE   ? RG_PRAM  :
           a < MCART_BASE  ? RG_VRAM  :
           a < MIRROR_BASE ? RG_MCART :
           a < MCART2_BASE ? RG_MIRROR : RG_MCART;
  endfunction
endpackage

// File: rtl/studio2_addr_decode.sv
// studio2_addr_decode: region decode, RAM mirror remap and write-protect flag
module studio2_addr_decode
  import studio2_pkg::*;
#(
  parameter int AW         = 12,
  parameter bit MIRROR_RAM = 1'b1,
  parameter bit ROM_WP     = 1'b1
) (
  input  logic [AW-1:0] i_addr,
  output logic [AW-1:0] o_addr,
  output logic          o_wp
);
  region_t w_region;
  assign w_region = region_of(i_addr[11:0]);
  // Mirror window 0C00-0DFF folds onto 0800-09FF by dropping address bit 10
  assign o_addr = (MIRROR_RAM && w_region == RG_MIRROR) ? (i_addr & ~(AW'(1) << 10)) : i_addr;
  assign o_wp   = ROM_WP && (w_region == RG_ROM || w_region == RG_CART);
endmodule

// File: rtl/studio2_mem_arbiter.sv
// studio2_mem_arbiter: CPU / display DMA / loader arbitration onto one synchronous RAM port
module studio2_mem_arbiter
  import studio2_pkg::*;
#(
  parameter int AW         = 12,
  parameter int DW         = 8,
  parameter bit MIRROR_RAM = 1'b1,
  parameter bit ROM_WP     = 1'b1
) (
  input  logic          clk,
  input  logic          resetq,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [15:0]   cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_wp_err,
  input  logic          dma_req,
  input  logic [15:0]   dma_addr,
  output logic          dma_ack,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  input  logic          ld_active,
  input  logic          ld_cart,
  input  logic          ld_wr,
  input  logic [24:0]   ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_overflow,
  output logic          mem_ce,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  state_t        r_state, w_next;
  logic          r_drain, r_ld_active_d;
  logic          w_run, w_gnt_dma, w_gnt_cpu, w_ld_go, w_ld_ovf, w_wp, w_cpu_drop;
  logic [15:0]   w_sel_addr;
  logic [AW-1:0] w_map_addr, w_ld_addr;
  logic          r_v1, r_v2;
  owner_t        r_o1, r_o2;
  // A requester granted last cycle sits out this one, so DMA and CPU alternate
  assign w_gnt_dma  = w_run && dma_req && !dma_ack;
  assign w_gnt_cpu  = w_run && cpu_req && !cpu_ack && !w_gnt_dma;
  assign w_sel_addr = w_gnt_dma ? dma_addr : cpu_addr;
  assign w_cpu_drop = cpu_we && w_wp;
  assign w_ld_go    = (r_state == ST_LOAD) && ld_active && ld_wr;
  assign w_ld_ovf   = ld_addr >= LD_WINDOW;
  assign w_ld_addr  = AW'(ld_cart ? CART_BASE : ROM_BASE) + AW'(ld_addr[9:0]);
  studio2_addr_decode #(.AW(AW), .MIRROR_RAM(MIRROR_RAM), .ROM_WP(ROM_WP)) u_decode (
    .i_addr (w_sel_addr[AW-1:0]),
    .o_addr (w_map_addr),
    .o_wp   (w_wp)
  );
  // Mode register plus two-cycle drain counter and loader-activity edge tracker
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_state       <= ST_RUN;
      r_drain       <= 1'b0;
      r_ld_active_d <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_drain       <= (r_state == ST_DRAIN) ? ~r_drain : 1'b0;
      r_ld_active_d <= ld_active;
    end
  end
  // Next mode; grants are only issued in RUN while no download is starting
  always_comb begin
    w_next = r_state;
    w_run  = 1'b0;
    w_next = (r_state == ST_RUN && ld_active)   ? ST_LOAD  :
             (r_state == ST_LOAD && !ld_active) ? ST_DRAIN :
             (r_state == ST_DRAIN && r_drain)   ? ST_RUN   : r_state;
    w_run  = (r_state == ST_RUN) && !ld_active;
  end
  // Grant pulses and the registered memory command
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_wp_err <= 1'b0;
      mem_ce     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      cpu_ack    <= w_gnt_cpu;
      dma_ack    <= w_gnt_dma;
      cpu_wp_err <= w_gnt_cpu && w_cpu_drop;
      mem_ce     <= w_gnt_dma || (w_gnt_cpu && !w_cpu_drop) || (w_ld_go && !w_ld_ovf);
      mem_wr     <= (w_gnt_cpu && cpu_we && !w_wp) || (w_ld_go && !w_ld_ovf);
      mem_addr   <= w_ld_go ? w_ld_addr : (w_gnt_dma || w_gnt_cpu) ? w_map_addr : mem_addr;
      mem_wdata  <= w_ld_go ? ld_data : w_gnt_cpu ? cpu_wdata : mem_wdata;
    end
  end
  // Two-stage read tag pipeline steering returned data to its owner
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_o1       <= OWN_CPU;
      r_o2       <= OWN_CPU;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      r_v1       <= w_gnt_dma || (w_gnt_cpu && !cpu_we);
      r_o1       <= w_gnt_dma ? OWN_DMA : OWN_CPU;
      r_v2       <= r_v1;
      r_o2       <= r_o1;
      cpu_rvalid <= r_v2 && r_o2 == OWN_CPU;
      dma_rvalid <= r_v2 && r_o2 == OWN_DMA;
      cpu_rdata  <= (r_v2 && r_o2 == OWN_CPU) ? mem_rdata : cpu_rdata;
      dma_rdata  <= (r_v2 && r_o2 == OWN_DMA) ? mem_rdata : dma_rdata;
    end
  end
  // Sticky loader overflow, cleared when a new download begins
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) ld_overflow <= 1'b0;
    else ld_overflow <= (ld_active && !r_ld_active_d) ? 1'b0 : (w_ld_go && w_ld_ovf) ? 1'b1 : ld_overflow;
  end
endmodule
